// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register indices for rename, with a retire-time head copy for mispredict restore.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state immediately
//   alloc_req      rename asks for one destination preg this cycle
//   alloc_gnt      request granted; alloc_pr is consumed at the next edge
//   alloc_pr       preg at the head (combinational)
//   free_enable    retiring instruction returns free_pr (its old dest); preg 0 is ignored
//   retire_enable  a retiring instruction that allocated a dest advances the retired head
//   restore_enable mispredict: roll head back to the retired head, reclaiming speculative pregs
//   empty          no stored free pregs
//   free_count     number of stored free pregs
//   overflow       sticky: a push arrived while the list was full
// Optional feature: define FREE_LIST_BYPASS_EN to grant a returning preg straight through an empty list.
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif
module free_list #(
    parameter int NUM_PREGS = `PHYS_REG_SZ,
    parameter int DEPTH = NUM_PREGS - 1,
    parameter int PRW = `PHYS_REG_IDX_SZ + 1,
    parameter int CW = `PHYS_REG_IDX_SZ + 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           alloc_req,
    output logic           alloc_gnt,
    output logic [PRW-1:0] alloc_pr,
    input  logic           free_enable,
    input  logic [PRW-1:0] free_pr,
    input  logic           retire_enable,
    input  logic           restore_enable,
    output logic           empty,
    output logic [CW-1:0]  free_count,
    output logic           overflow
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [PRW-1:0] entries [DEPTH];
    logic [IW-1:0] head, tail, rhead, rhead_next;
    logic [CW-1:0] count, spec_cnt, count_next, spec_next;
    logic push_req, full, grant, byp, push, take;
    function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
        return (p == LAST) ? '0 : p + IW'(1);
    endfunction
    assign push_req = free_enable && free_pr != '0;
    assign full = count == FULL;
    assign empty = count == '0;
    assign grant = alloc_req && !empty && !restore_enable;
`ifdef FREE_LIST_BYPASS_EN
    // An empty list hands the returning preg straight to rename; it never touches the ring.
    assign byp = empty && push_req && alloc_req && !restore_enable;
`else
    assign byp = 1'b0;
`endif
    assign push = push_req && !full && !byp;
    assign take = grant || byp;
    assign alloc_gnt = take;
    assign alloc_pr = byp ? free_pr : entries[head];
    assign free_count = count;
    assign rhead_next = retire_enable ? inc(rhead) : rhead;
    assign count_next = count + CW'(push) - CW'(grant);
    assign spec_next = spec_cnt + CW'(take) - CW'(retire_enable);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= PRW'(i + 1);
            head <= '0;
            tail <= '0;
            rhead <= '0;
            count <= FULL;
            spec_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                entries[tail] <= free_pr;
                tail <= inc(tail);
            end
            if (push_req && full) overflow <= 1'b1;
            rhead <= rhead_next;
            // Restore: everything between the retired head and the head returns to the free pool.
            head <= restore_enable ? rhead_next : (grant ? inc(head) : head);
            count <= restore_enable ? count_next + spec_next : count_next;
            spec_cnt <= restore_enable ? '0 : spec_next;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: table vectors, directed corner sequences and a queue-model random run for free_list.
`timescale 1ns/1ps
module tb_free_list;
    logic clk = 1'b0;
    logic reset;
    logic alloc_req, alloc_gnt, free_enable, retire_enable, restore_enable, empty, overflow;
    logic [6:0] alloc_pr, free_pr;
    logic [7:0] free_count;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    free_list #(.NUM_PREGS(64)) dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_pr(alloc_pr),
        .free_enable(free_enable), .free_pr(free_pr), .retire_enable(retire_enable),
        .restore_enable(restore_enable), .empty(empty), .free_count(free_count), .overflow(overflow)
    );
    typedef struct {
        int a, fe, fp, rt, rs, gnt, pr, cnt;
    } vec_t;
    vec_t tv[14];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic drive(input int a, input int fe, input int fp, input int rt, input int rs);
        @(negedge clk);
        alloc_req = a[0];
        free_enable = fe[0];
        free_pr = 7'(fp);
        retire_enable = rt[0];
        restore_enable = rs[0];
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        alloc_req = 1'b0;
        free_enable = 1'b0;
        free_pr = '0;
        retire_enable = 1'b0;
        restore_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic grant_all();
        for (int i = 1; i <= 63; i++) begin
            drive(1, 0, 0, 0, 0);
            chk("drain_gnt", alloc_gnt, 1);
            chk("drain_pr", alloc_pr, i);
        end
        drive(1, 0, 0, 0, 0);
        chk("drained_empty", empty, 1);
        chk("drained_gnt", alloc_gnt, 0);
    endtask
    initial begin
        tv[0]  = '{1, 0, 0, 0, 0, 1, 1, 63};
        tv[1]  = '{1, 0, 0, 0, 0, 1, 2, 62};
        tv[2]  = '{1, 0, 0, 0, 0, 1, 3, 61};
        tv[3]  = '{1, 0, 0, 0, 0, 1, 4, 60};
        tv[4]  = '{1, 0, 0, 0, 0, 1, 5, 59};
        tv[5]  = '{0, 0, 0, 1, 0, 0, 6, 58};
        tv[6]  = '{0, 0, 0, 1, 0, 0, 6, 58};
        tv[7]  = '{1, 0, 0, 0, 1, 0, 6, 58};
        tv[8]  = '{0, 1, 0, 0, 0, 0, 3, 61};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 3, 61};
        tv[10] = '{1, 0, 0, 0, 0, 1, 3, 61};
        tv[11] = '{1, 0, 0, 0, 0, 1, 4, 60};
        tv[12] = '{1, 1, 1, 1, 1, 0, 5, 59};
        tv[13] = '{0, 0, 0, 0, 0, 0, 4, 61};
        do_reset();
        #1;
        chk("reset_count", free_count, 63);
        chk("reset_pr", alloc_pr, 1);
        chk("reset_empty", empty, 0);
        chk("reset_overflow", overflow, 0);
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].a, tv[i].fe, tv[i].fp, tv[i].rt, tv[i].rs);
            chk($sformatf("vec%0d_gnt", i), alloc_gnt, tv[i].gnt);
            chk($sformatf("vec%0d_pr", i), alloc_pr, tv[i].pr);
            chk($sformatf("vec%0d_cnt", i), free_count, tv[i].cnt);
            chk($sformatf("vec%0d_empty", i), empty, tv[i].cnt == 0);
        end
        // Empty list with a returning preg and a request in the same cycle.
        do_reset();
        grant_all();
        drive(1, 1, 9, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
        chk("byp_gnt", alloc_gnt, 1);
        chk("byp_pr", alloc_pr, 9);
        drive(0, 0, 0, 0, 0);
        chk("byp_cnt", free_count, 0);
`else
        chk("nobyp_gnt", alloc_gnt, 0);
        drive(0, 0, 0, 0, 0);
        chk("nobyp_cnt", free_count, 1);
        chk("nobyp_pr", alloc_pr, 9);
`endif
        // Refill 40 after a full drain: the tail wraps so the first push sits at slot 0.
        do_reset();
        grant_all();
        for (int k = 0; k < 40; k++) drive(0, 1, 40 - k, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("refill_cnt", free_count, 40);
        chk("refill_gnt", alloc_gnt, 1);
        chk("refill_pr", alloc_pr, 40);
        // Push into a full list.
        do_reset();
        drive(0, 1, 5, 0, 0);
        chk("ovf_before", overflow, 0);
        drive(0, 0, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", free_count, 63);
        chk("ovf_pr", alloc_pr, 1);
        // Asynchronous reset in the middle of activity.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("pre_areset_pr", alloc_pr, 3);
        #1 reset = 1'b1;
        #1;
        chk("areset_pr", alloc_pr, 1);
        chk("areset_cnt", free_count, 63);
        chk("areset_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        chk("post_areset_gnt", alloc_gnt, 1);
        chk("post_areset_pr", alloc_pr, 1);
        // Random run against a queue model: free_q holds allocatable pregs in order,
        // spec_q holds pregs handed out since the last retirement, oldest first.
        begin
            int free_q[$];
            int spec_q[$];
            do_reset();
            for (int i = 1; i <= 63; i++) free_q.push_back(i);
            for (int cyc = 0; cyc < 4000; cyc++) begin
                int a, fe, fp, rt, rs, eg, pu;
                int ppush = ((cyc / 250) % 2 == 0) ? 20 : 65;
                a = $urandom_range(0, 99) < 55;
                fe = $urandom_range(0, 99) < ppush;
                fp = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
                if (fe != 0 && fp != 0 && free_q.size() + spec_q.size() >= 63) fe = 0;
                if (fe != 0 && fp != 0 && free_q.size() == 0) a = 0;
                rt = (spec_q.size() > 0) && ($urandom_range(0, 99) < 30);
                rs = $urandom_range(0, 99) < 4;
                drive(a, fe, fp, rt, rs);
                eg = (a != 0 && free_q.size() > 0 && rs == 0) ? 1 : 0;
                pu = (fe != 0 && fp != 0) ? 1 : 0;
                chk("rnd_gnt", alloc_gnt, eg);
                if (eg != 0) chk("rnd_pr", alloc_pr, free_q[0]);
                chk("rnd_cnt", free_count, free_q.size());
                chk("rnd_empty", empty, free_q.size() == 0);
                if (rt != 0) void'(spec_q.pop_front());
                if (eg != 0) spec_q.push_back(free_q.pop_front());
                if (pu != 0) free_q.push_back(fp);
                if (rs != 0) while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
            end
            drive(0, 0, 0, 0, 0);
            chk("rnd_final_cnt", free_count, free_q.size());
            chk("rnd_overflow", overflow, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
